avalon_reg_bank: RTL
====================

Name: avalon_reg_bank

Overview:
- Parametrised Avalon-MM slave register file; successor to the fixed four-word test slave.
- Generalises data width and register count, and adds byte-enable writes, a configurable-latency pipelined read path with readdatavalid, a write-1-to-clear event status register, and a maskable level interrupt.
- Sits on the Avalon bus behind the interconnect as the team's generic control/status block.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8, range 8..64.
- ADDR_W, 3, word address width; NUM_REGS = 2**ADDR_W; minimum 2.
- READ_LATENCY, 1, cycles from read accept to oReaddatavalid; range 1..4.

Ports:
- iClk  in  1  single clock, all logic on its rising edge.
- iReset  in  1  asynchronous, active-low reset.
- iChipselect  in  1  slave select.
- iWrite_n  in  1  active-low write strobe.
- iRead_n  in  1  active-low read strobe.
- iAddress  in  ADDR_W  word address.
- iByteenable  in  DATA_W/8  per-byte write enable; ignored on reads.
- iData  in  DATA_W  write data.
- oData  out  DATA_W  read data, qualified by oReaddatavalid.
- oReaddatavalid  out  1  one-cycle pulse per accepted read.
- iEvent  in  DATA_W  hardware event pulses, one per status bit.
- oIrq  out  1  level interrupt, registered.

Behaviour:
- Register map:
  - Addresses 0..NUM_REGS-3 are general RW (GPR).
  - Address NUM_REGS-2 is STATUS: read returns sticky bits; a write of 1 clears the bit where its byte is enabled; a write of 0 has no effect.
  - Address NUM_REGS-1 is IRQ_MASK: RW.
- Write accept: iChipselect=1 and iWrite_n=0. Only bytes with iByteenable=1 are updated; other bytes hold.
- Read accept: iChipselect=1, iRead_n=0 and iWrite_n=1. If both strobes are low, the write wins and no read is issued.
- No waitrequest; one access is accepted per cycle and back-to-back reads are supported.
- Read pipeline:
  - Register contents are sampled at the accept edge, before any same-edge STATUS set.
  - oData and oReaddatavalid appear exactly READ_LATENCY cycles after the accept edge; valid is high for one cycle.
  - oData holds its last value while valid is low.
- STATUS update each edge: status <= (status & ~w1c_mask) | iEvent. If a bit is set and cleared in the same cycle, the set wins.
- oIrq <= |(status & irq_mask), one register stage. An event in cycle n sets STATUS at edge n; oIrq rises at edge n+1.
- Clearing the last enabled bit drops oIrq one cycle after the clearing write edge. Changing the mask takes effect on the same timing.
- Reset (iReset=0, async):
  - All GPRs, STATUS, IRQ_MASK, oData, oReaddatavalid and oIrq go to 0.
  - Any in-flight reads are flushed; no valid pulse is issued for them after release.
- Chipselect low: strobes are ignored, while STATUS/IRQ logic keeps running.

Decomposition:
- Package avalon_reg_pkg holds:
  - the STATUS/IRQ_MASK offset functions of ADDR_W;
  - the byte-enable merge function (old, new, be -> merged word);
  - the READ_LATENCY range constants.
- Sub-module avalon_rd_pipe: a READ_LATENCY-deep delay line carrying {valid, data}, with async active-low clear.

Test Plan:
- Reset then read GPR0 with READ_LATENCY=1 -> oReaddatavalid exactly 1 cycle later, oData=0x00000000; oIrq=0.
- Write GPR1=0xDEADBEEF with be=4'b1111, then write 0x11223344 with be=4'b0101, read -> 0xDE22BE44.
- READ_LATENCY=3, reads of GPR0..GPR3 on 4 consecutive cycles after writing 0x10,0x20,0x30,0x40 -> 4 consecutive valid pulses 3 cycles after each accept, data 0x10,0x20,0x30,0x40.
- Set IRQ_MASK=0x1, pulse iEvent=0x5 -> STATUS reads 0x5, oIrq high one cycle after the set; write STATUS=0x1 -> reads 0x4, oIrq low the cycle after; write STATUS=0x4 in the same cycle as an iEvent[2] pulse -> bit stays 1.
- Assert iWrite_n=0 and iRead_n=0 together to GPR0 with 0xA5 -> GPR0=0xA5, no oReaddatavalid pulse.
- Issue a read with READ_LATENCY=2, assert iReset for one cycle in the next cycle -> no valid pulse, and all registers and outputs are 0 after release.

Source files
------------

// File: rtl/avalon_reg_pkg.sv
// rtl/avalon_reg_pkg.sv - shared constants and helpers for the Avalon-MM register bank
package avalon_reg_pkg;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 4;

    // STATUS and IRQ_MASK occupy the top two word addresses.
    function automatic int unsigned status_offset(input int unsigned addr_w);
        return (32'd1 << addr_w) - 32'd2;
    endfunction

    function automatic int unsigned irq_mask_offset(input int unsigned addr_w);
        return (32'd1 << addr_w) - 32'd1;
    endfunction

    // Helpers work on the widest legal word; callers cast to DATA_W.
    function automatic logic [63:0] be_expand(input logic [7:0] be);
        logic [63:0] m;
        m = '0;
        for (int b = 0; b < 8; b++) begin
            m[b*8 +: 8] = {8{be[b]}};
        end
        return m;
    endfunction

    function automatic logic [63:0] be_merge(input logic [63:0] old_w,
                                             input logic [63:0] new_w,
                                             input logic [7:0]  be);
        logic [63:0] m;
        m = be_expand(be);
        return (old_w & ~m) | (new_w & m);
    endfunction

endpackage

// File: rtl/avalon_rd_pipe.sv
// rtl/avalon_rd_pipe.sv - fixed-depth {valid, data} delay line for the read return path
module avalon_rd_pipe #(
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iValid,
    input  logic [DATA_W-1:0] iData,
    output logic              oValid,
    output logic [DATA_W-1:0] oData
);

    logic [LATENCY-1:0]             vld_q;
    logic [LATENCY-1:0][DATA_W-1:0] dat_q;

    // Data stages only load behind a valid, so the last stage holds between pulses.
    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q[0] <= iValid;
            if (iValid) begin
                dat_q[0] <= iData;
            end
            for (int s = 1; s < LATENCY; s++) begin
                vld_q[s] <= vld_q[s-1];
                if (vld_q[s-1]) begin
                    dat_q[s] <= dat_q[s-1];
                end
            end
        end
    end

    assign oValid = vld_q[LATENCY-1];
    assign oData  = dat_q[LATENCY-1];

endmodule

// File: rtl/avalon_reg_bank.sv
// rtl/avalon_reg_bank.sv - Avalon-MM slave: GPRs, W1C event STATUS, IRQ mask, pipelined reads
module avalon_reg_bank
    import avalon_reg_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 3,
    parameter int READ_LATENCY = 1
) (
    input  logic                iClk,
    input  logic                iReset,
    input  logic                iChipselect,
    input  logic                iWrite_n,
    input  logic                iRead_n,
    input  logic [ADDR_W-1:0]   iAddress,
    input  logic [DATA_W/8-1:0] iByteenable,
    input  logic [DATA_W-1:0]   iData,
    output logic [DATA_W-1:0]   oData,
    output logic                oReaddatavalid,
    input  logic [DATA_W-1:0]   iEvent,
    output logic                oIrq
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(status_offset(ADDR_W));
    localparam logic [ADDR_W-1:0] MASK_ADDR   = ADDR_W'(irq_mask_offset(ADDR_W));

    if (READ_LATENCY < RD_LAT_MIN || READ_LATENCY > RD_LAT_MAX) begin : g_bad_latency
        $error("avalon_reg_bank: READ_LATENCY out of range");
    end
    if (DATA_W % 8 != 0 || DATA_W < 8 || DATA_W > 64 || ADDR_W < 1) begin : g_bad_shape
        $error("avalon_reg_bank: unsupported DATA_W/ADDR_W");
    end

    logic [DATA_W-1:0] gpr_q [NUM_REGS];
    logic [DATA_W-1:0] gpr_d [NUM_REGS];
    logic [DATA_W-1:0] status_q, status_d;
    logic [DATA_W-1:0] mask_q, mask_d;
    logic              irq_q, irq_d;

    logic              wr_acc, rd_acc;
    logic [DATA_W-1:0] cur_word, merged, be_mask, w1c;

    assign wr_acc = iChipselect & ~iWrite_n;
    assign rd_acc = iChipselect & ~iRead_n & iWrite_n;

    assign be_mask = DATA_W'(be_expand(8'(iByteenable)));
    assign merged  = DATA_W'(be_merge(64'(cur_word), 64'(iData), 8'(iByteenable)));

    always_comb begin
        cur_word = gpr_q[iAddress];
        if (iAddress == STATUS_ADDR) begin
            cur_word = status_q;
        end else if (iAddress == MASK_ADDR) begin
            cur_word = mask_q;
        end
    end

    // The top two GPR slots are shadowed by STATUS/IRQ_MASK and never written.
    always_comb begin
        gpr_d  = gpr_q;
        mask_d = mask_q;
        w1c    = '0;
        if (wr_acc) begin
            if (iAddress == STATUS_ADDR) begin
                w1c = iData & be_mask;
            end else if (iAddress == MASK_ADDR) begin
                mask_d = merged;
            end else begin
                gpr_d[iAddress] = merged;
            end
        end
        status_d = (status_q & ~w1c) | iEvent;
        irq_d    = |(status_q & mask_q);
    end

    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            gpr_q    <= '{default: '0};
            status_q <= '0;
            mask_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            gpr_q    <= gpr_d;
            status_q <= status_d;
            mask_q   <= mask_d;
            irq_q    <= irq_d;
        end
    end

    assign oIrq = irq_q;

    avalon_rd_pipe #(
        .DATA_W  (DATA_W),
        .LATENCY (READ_LATENCY)
    ) u_rd_pipe (
        .iClk   (iClk),
        .iReset (iReset),
        .iValid (rd_acc),
        .iData  (cur_word),
        .oValid (oReaddatavalid),
        .oData  (oData)
    );

endmodule
